ioctl_loader: RTL and testbench

- Upstream download stage that feeds the video frame-buffer write port (ioctl_wr / ioctl_addr / ioctl_data).
- Accepts a byte stream from the host side over a valid/ready handshake.
- Assigns sequential addresses and emits paced single-cycle write strobes.
- Drives the `progress` indicator while an image load is in flight.

---
 rtl/ioctl_loader.sv | 115 +++++++++++
 tb/tb_ioctl_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_loader.sv
// Download loader: turns a valid/ready byte stream into paced, sequentially addressed ioctl write strobes.
// Optional IOCTL_LOADER_CHECKSUM_EN adds dl_sum, the modulo-256 sum of bytes written since the last dl_start.
module ioctl_loader #(
    parameter int ADDR_W      = 14,
    parameter int IMAGE_BYTES = 16000,
    parameter int WR_GAP      = 0
) (
    input  logic              pixel_clock,
    input  logic              reset,
    input  logic              dl_start,
    input  logic              dl_abort,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_data,
    output logic              progress,
    output logic              dl_done,
    output logic [ADDR_W:0]   byte_count
`ifdef IOCTL_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]        dl_sum
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(IMAGE_BYTES);
    localparam logic [3:0]      GAP_RELOAD = 4'(WR_GAP);

    state_t     state;
    state_t     state_next;
    logic [3:0] gap_cnt;
    logic       accept;

    // A byte arriving alongside a control pulse is refused so a restart never inherits a stray byte.
    always_comb begin
        s_ready    = (state == LOAD) && (gap_cnt == 4'd0) && (byte_count < LAST_COUNT);
        accept     = s_ready && s_valid && !dl_start && !dl_abort;
        progress   = (state == LOAD);
        dl_done    = (state == DONE);
        state_next = state;
        case (state)
            IDLE: begin
                if (dl_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (dl_start) begin
                    state_next = LOAD;
                end else if (dl_abort) begin
                    state_next = IDLE;
                end else if (byte_count >= LAST_COUNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (dl_start) begin
                    state_next = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ioctl_wr   <= 1'b0;
            ioctl_addr <= '0;
            ioctl_data <= 8'd0;
            byte_count <= '0;
            gap_cnt    <= 4'd0;
        end else begin
            state    <= state_next;
            ioctl_wr <= accept;
            if (accept) begin
                ioctl_addr <= byte_count[ADDR_W-1:0];
                ioctl_data <= s_data;
            end
            if (dl_start) begin
                byte_count <= '0;
            end else if (accept) begin
                byte_count <= byte_count + 1'b1;
            end
            // The gap counter starts at WR_GAP on the strobe cycle, so the next accept lands WR_GAP+1 cycles later.
            if (dl_start) begin
                gap_cnt <= 4'd0;
            end else if (accept) begin
                gap_cnt <= GAP_RELOAD;
            end else if (gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

`ifdef IOCTL_LOADER_CHECKSUM_EN
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            dl_sum <= 8'd0;
        end else if (dl_start) begin
            dl_sum <= 8'd0;
        end else if (accept) begin
            dl_sum <= dl_sum + s_data;
        end
    end
`endif

endmodule

// File: tb/tb_ioctl_loader.sv
// Directed bench for ioctl_loader: a no-gap instance and a WR_GAP=2 instance share the stream inputs.
// Each instance has its own dl_start so only the one under test leaves IDLE/DONE.
module tb_ioctl_loader;

    logic       pixel_clock = 1'b0;
    logic       reset;
    logic       dl_start0;
    logic       dl_start2;
    logic       dl_abort;
    logic [7:0] s_data;
    logic       s_valid;

    logic       s_ready0, ioctl_wr0, progress0, dl_done0;
    logic [3:0] ioctl_addr0;
    logic [7:0] ioctl_data0;
    logic [4:0] byte_count0;
    logic       s_ready2, ioctl_wr2, progress2, dl_done2;
    logic [3:0] ioctl_addr2;
    logic [7:0] ioctl_data2;
    logic [4:0] byte_count2;
`ifdef IOCTL_LOADER_CHECKSUM_EN
    logic [7:0] dl_sum0;
    logic [7:0] dl_sum2;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] t1_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] cs_bytes [4] = '{8'hF0, 8'h20, 8'h01, 8'h02};

    always #5 pixel_clock = ~pixel_clock;

    ioctl_loader #(.ADDR_W(4), .IMAGE_BYTES(4), .WR_GAP(0)) u_dut0 (
        .pixel_clock(pixel_clock),
        .reset      (reset),
        .dl_start   (dl_start0),
        .dl_abort   (dl_abort),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready0),
        .ioctl_wr   (ioctl_wr0),
        .ioctl_addr (ioctl_addr0),
        .ioctl_data (ioctl_data0),
        .progress   (progress0),
        .dl_done    (dl_done0),
        .byte_count (byte_count0)
`ifdef IOCTL_LOADER_CHECKSUM_EN
        ,
        .dl_sum     (dl_sum0)
`endif
    );

    ioctl_loader #(.ADDR_W(4), .IMAGE_BYTES(4), .WR_GAP(2)) u_dut2 (
        .pixel_clock(pixel_clock),
        .reset      (reset),
        .dl_start   (dl_start2),
        .dl_abort   (dl_abort),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready2),
        .ioctl_wr   (ioctl_wr2),
        .ioctl_addr (ioctl_addr2),
        .ioctl_data (ioctl_data2),
        .progress   (progress2),
        .dl_done    (dl_done2),
        .byte_count (byte_count2)
`ifdef IOCTL_LOADER_CHECKSUM_EN
        ,
        .dl_sum     (dl_sum2)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one cycle of inputs, then returns 1 ns after the edge that sampled them.
    task automatic applyStimulus(input logic start0, input logic start2, input logic abort,
                                 input logic valid, input logic [7:0] data);
        dl_start0 = start0;
        dl_start2 = start2;
        dl_abort  = abort;
        s_valid   = valid;
        s_data    = data;
        @(posedge pixel_clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        dl_start0 = 1'b0;
        dl_start2 = 1'b0;
        dl_abort  = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'd0;
        repeat (2) @(posedge pixel_clock);
        #1;
        checkOutput("rst_wr",    32'(ioctl_wr0), 0);
        checkOutput("rst_addr",  32'(ioctl_addr0), 0);
        checkOutput("rst_data",  32'(ioctl_data0), 0);
        checkOutput("rst_prog",  32'(progress0), 0);
        checkOutput("rst_done",  32'(dl_done0), 0);
        checkOutput("rst_count", 32'(byte_count0), 0);
        checkOutput("rst_ready", 32'(s_ready0), 0);
        reset = 1'b0;

        $display("[TB] back-to-back load, WR_GAP=0");
        applyStimulus(1, 0, 0, 0, 8'h00);
        checkOutput("t1_prog",  32'(progress0), 1);
        checkOutput("t1_count0", 32'(byte_count0), 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_ready", 32'(s_ready0), 1);
            applyStimulus(0, 0, 0, 1, t1_bytes[i]);
            checkOutput("t1_wr",    32'(ioctl_wr0), 1);
            checkOutput("t1_addr",  32'(ioctl_addr0), 32'(i));
            checkOutput("t1_data",  32'(ioctl_data0), 32'(t1_bytes[i]));
            checkOutput("t1_count", 32'(byte_count0), 32'(i + 1));
        end
        checkOutput("t1_ready_full", 32'(s_ready0), 0);
        checkOutput("t1_prog_full",  32'(progress0), 1);
        applyStimulus(0, 0, 0, 1, 8'h99);
        checkOutput("t1_wr_end",   32'(ioctl_wr0), 0);
        checkOutput("t1_prog_end", 32'(progress0), 0);
        checkOutput("t1_done",     32'(dl_done0), 1);
        checkOutput("t1_final",    32'(byte_count0), 4);

        $display("[TB] paced load, WR_GAP=2");
        applyStimulus(0, 1, 0, 0, 8'h00);
        for (int c = 0; c < 12; c++) begin
            checkOutput("t2_ready", 32'(s_ready2), 32'(c % 3 == 0));
            checkOutput("t2_wr",    32'(ioctl_wr2), 32'(c % 3 == 1));
            if (c % 3 == 1) begin
                checkOutput("t2_addr", 32'(ioctl_addr2), 32'((c - 1) / 3));
                checkOutput("t2_data", 32'(ioctl_data2), 32'(8'(8'hA0 + c - 1)));
            end
            if (c == 11) begin
                checkOutput("t2_done", 32'(dl_done2), 1);
                checkOutput("t2_prog", 32'(progress2), 0);
            end
            applyStimulus(0, 0, 0, 1, 8'(8'hA0 + c));
        end

        $display("[TB] restart from DONE with gappy s_valid");
        applyStimulus(1, 0, 0, 0, 8'h00);
        checkOutput("t3_done_clr", 32'(dl_done0), 0);
        checkOutput("t3_count0",   32'(byte_count0), 0);
        applyStimulus(0, 0, 0, 1, 8'h55);
        checkOutput("t3_wr_a",   32'(ioctl_wr0), 1);
        checkOutput("t3_addr_a", 32'(ioctl_addr0), 0);
        checkOutput("t3_data_a", 32'(ioctl_data0), 32'h55);
        applyStimulus(0, 0, 0, 0, 8'h00);
        checkOutput("t3_idle_1", 32'(ioctl_wr0), 0);
        applyStimulus(0, 0, 0, 0, 8'h00);
        checkOutput("t3_idle_2", 32'(ioctl_wr0), 0);
        applyStimulus(0, 0, 0, 1, 8'h66);
        checkOutput("t3_wr_b",    32'(ioctl_wr0), 1);
        checkOutput("t3_addr_b",  32'(ioctl_addr0), 1);
        checkOutput("t3_data_b",  32'(ioctl_data0), 32'h66);
        checkOutput("t3_count_b", 32'(byte_count0), 2);
        applyStimulus(0, 0, 0, 0, 8'h00);
        checkOutput("t3_hold", 32'(byte_count0), 2);

        $display("[TB] abort after two bytes, then restart");
        applyStimulus(0, 0, 1, 0, 8'h00);
        checkOutput("t4_prog",  32'(progress0), 0);
        checkOutput("t4_done",  32'(dl_done0), 0);
        checkOutput("t4_count", 32'(byte_count0), 2);
        checkOutput("t4_ready", 32'(s_ready0), 0);
        applyStimulus(1, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 1, 8'h77);
        checkOutput("t4_wr",   32'(ioctl_wr0), 1);
        checkOutput("t4_addr", 32'(ioctl_addr0), 0);
        checkOutput("t4_data", 32'(ioctl_data0), 32'h77);

        $display("[TB] asynchronous reset on third byte");
        applyStimulus(0, 0, 0, 1, 8'h78);
        applyStimulus(0, 0, 0, 1, 8'h79);
        checkOutput("t5_wr3",   32'(ioctl_wr0), 1);
        checkOutput("t5_addr3", 32'(ioctl_addr0), 2);
        #2 reset = 1'b1;
        #1;
        checkOutput("t5_wr",    32'(ioctl_wr0), 0);
        checkOutput("t5_addr",  32'(ioctl_addr0), 0);
        checkOutput("t5_data",  32'(ioctl_data0), 0);
        checkOutput("t5_count", 32'(byte_count0), 0);
        checkOutput("t5_prog",  32'(progress0), 0);
        checkOutput("t5_ready", 32'(s_ready0), 0);
        applyStimulus(0, 0, 0, 1, 8'h7A);
        checkOutput("t5_wr_rst", 32'(ioctl_wr0), 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 1, 8'h7A);
            checkOutput("t5_no_wr",   32'(ioctl_wr0), 0);
            checkOutput("t5_no_prog", 32'(progress0), 0);
        end

        $display("[TB] start wins over abort, checksum load");
        applyStimulus(1, 0, 1, 0, 8'h00);
        checkOutput("t6_prog", 32'(progress0), 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, cs_bytes[i]);
            checkOutput("t6_data", 32'(ioctl_data0), 32'(cs_bytes[i]));
        end
        applyStimulus(0, 0, 0, 0, 8'h00);
        checkOutput("t6_done",  32'(dl_done0), 1);
        checkOutput("t6_count", 32'(byte_count0), 4);
`ifdef IOCTL_LOADER_CHECKSUM_EN
        checkOutput("t6_sum", 32'(dl_sum0), 32'h13);
`endif
        applyStimulus(1, 0, 0, 0, 8'h00);
        checkOutput("t6_restart_done", 32'(dl_done0), 0);
`ifdef IOCTL_LOADER_CHECKSUM_EN
        checkOutput("t6_sum_clr", 32'(dl_sum0), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
